rng_fetch_ctrl: RTL and testbench

RNG_FETCH_CTRL -- requirements
Module: rng_fetch_ctrl

---
 rtl/rng_fetch_pkg.sv | 21 ++
 rtl/rng_word_ser.sv | 53 +++++
 rtl/rng_fetch_ctrl.sv | 107 ++++++++++
 tb/tb_rng_fetch_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_fetch_pkg.sv
// Shared FSM state type, default sizing constants and a counter-width helper
// for the random-number fetch controller.
package rng_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_STREAM = 2'd3
  } state_e;

  localparam int unsigned NBITS      = 2048;
  localparam int unsigned WBITS      = 32;
  localparam int unsigned TMO_CYCLES = 4096;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rng_word_ser.sv
// Holds one generator result and streams it out least-significant word first
// over a valid/ready handshake.
module rng_word_ser
  import rng_fetch_pkg::*;
#(
  parameter int unsigned NBITS = rng_fetch_pkg::NBITS,
  parameter int unsigned WBITS = rng_fetch_pkg::WBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [NBITS-1:0] y_i,
  input  logic             active_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WBITS-1:0] data_o,
  output logic             last_o,
  output logic             last_hs_o
);

  localparam int unsigned NW = NBITS / WBITS;
  localparam int unsigned IDXW = cnt_width(NW);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NW - 1);

  logic [NBITS-1:0] buf_q;
  logic [IDXW-1:0]  idx_q;
  logic [WBITS-1:0] words [NW];
  logic             hs;

  for (genvar gi = 0; gi < NW; gi++) begin : g_word
    assign words[gi] = buf_q[gi*WBITS +: WBITS];
  end

  assign valid_o   = active_i;
  assign last_o    = active_i && (idx_q == LAST_IDX);
  assign data_o    = active_i ? words[idx_q] : '0;
  assign hs        = active_i && ready_i;
  assign last_hs_o = hs && last_o;

  // The last handshake leaves STREAM, so idx holds there rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      buf_q <= y_i;
      idx_q <= '0;
    end else if (hs && !last_o) begin
      idx_q <= idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/rng_fetch_ctrl.sv
// Requests one number from the random generator and streams it as words.
// Define RNG_FETCH_TIMEOUT_EN to abandon a request after TMO_CYCLES in WAIT.
module rng_fetch_ctrl
  import rng_fetch_pkg::*;
#(
  parameter int unsigned NBITS      = rng_fetch_pkg::NBITS,
  parameter int unsigned WBITS      = rng_fetch_pkg::WBITS,
  parameter int unsigned TMO_CYCLES = rng_fetch_pkg::TMO_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_p,
  input  logic             bypass,
  output logic             rng_enable_p,
  output logic             rng_bypass,
  input  logic [NBITS-1:0] rng_y,
  input  logic             rng_done_p,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [WBITS-1:0] word_data,
  output logic             word_last,
  output logic             busy,
  output logic             timeout_p
);

  state_e state_q, state_d;
  logic   bypass_q;
  logic   load;
  logic   last_hs;
  logic   tmo_hit;

  assign load         = (state_q == ST_WAIT) && rng_done_p;
  assign rng_enable_p = (state_q == ST_REQ);
  assign rng_bypass   = bypass_q;
  assign busy         = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_p) state_d = ST_REQ;
      ST_REQ:    state_d = ST_WAIT;
      ST_WAIT: begin
        if (rng_done_p)   state_d = ST_STREAM;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      ST_STREAM: if (last_hs) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bypass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start_p) bypass_q <= bypass;
    end
  end

`ifdef RNG_FETCH_TIMEOUT_EN
  localparam int unsigned TW = cnt_width(TMO_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          timeout_q;

  // A done arriving on the terminal count suppresses the timeout.
  assign tmo_hit   = (state_q == ST_WAIT) && !rng_done_p && (tmo_cnt_q == TMO_LAST);
  assign timeout_p = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == ST_REQ)
        tmo_cnt_q <= '0;
      else if (state_q == ST_WAIT && !rng_done_p && !tmo_hit)
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      timeout_q <= tmo_hit;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = |TMO_CYCLES;
  assign tmo_hit    = 1'b0;
  assign timeout_p  = 1'b0;
`endif

  rng_word_ser #(
    .NBITS(NBITS),
    .WBITS(WBITS)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .y_i      (rng_y),
    .active_i (state_q == ST_STREAM),
    .ready_i  (word_ready),
    .valid_o  (word_valid),
    .data_o   (word_data),
    .last_o   (word_last),
    .last_hs_o(last_hs)
  );

endmodule

// File: tb/tb_rng_fetch_ctrl.sv
// Scoreboard bench for rng_fetch_ctrl at NBITS=64, WBITS=32, TMO_CYCLES=16;
// honours RNG_FETCH_TIMEOUT_EN when it is defined for the build.
module tb_rng_fetch_ctrl;

  localparam int unsigned NBITS = 64;
  localparam int unsigned WBITS = 32;
  localparam int unsigned TMO   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_p = 1'b0;
  logic             bypass = 1'b0;
  logic             rng_enable_p;
  logic             rng_bypass;
  logic [NBITS-1:0] rng_y = '0;
  logic             rng_done_p = 1'b0;
  logic             word_valid;
  logic             word_ready = 1'b0;
  logic [WBITS-1:0] word_data;
  logic             word_last;
  logic             busy;
  logic             timeout_p;

  int errors = 0;
  int checks = 0;
  logic [WBITS:0] sb [$];

  rng_fetch_ctrl #(.NBITS(NBITS), .WBITS(WBITS), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start_p(start_p), .bypass(bypass),
    .rng_enable_p(rng_enable_p), .rng_bypass(rng_bypass),
    .rng_y(rng_y), .rng_done_p(rng_done_p),
    .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .word_last(word_last),
    .busy(busy), .timeout_p(timeout_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_num(input logic [NBITS-1:0] y, input int nwords);
    for (int w = 0; w < nwords; w++)
      sb.push_back({(w == 1), y[w*WBITS +: WBITS]});
  endtask

  // Full fetch with word_ready held high; returns in IDLE.
  task automatic fetch(input logic [NBITS-1:0] y, input logic bp);
    word_ready = 1'b1;
    bypass = bp; start_p = 1'b1;
    tick();
    start_p = 1'b0; bypass = 1'b0;
    tick();
    rng_y = y; rng_done_p = 1'b1; push_num(y, 2);
    tick();
    rng_done_p = 1'b0;
    tick();
    tick();
  endtask

  // Monitor: every handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (word_valid && word_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got %h expected none", word_data);
      end else begin
        logic [WBITS:0] e;
        e = sb.pop_front();
        checks++;
        if ({word_last, word_data} !== e) begin
          errors++;
          $display("FAIL word: got last=%b data=%h expected last=%b data=%h",
                   word_last, word_data, e[WBITS], e[WBITS-1:0]);
        end else begin
          $display("ok   word: last=%b data=%h", word_last, word_data);
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    @(negedge clk);
    check("reset_outputs",
          {rng_enable_p, rng_bypass, word_valid, word_last, busy, timeout_p, word_data},
          '0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Basic fetch
    word_ready = 1'b1;
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    @(negedge clk);
    check("enable_in_req", rng_enable_p, 1);
    check("busy_in_req", busy, 1);
    tick();
    @(negedge clk);
    check("enable_one_cycle", rng_enable_p, 0);
    rng_y = 64'h0123_4567_89AB_CDEF; rng_done_p = 1'b1;
    push_num(rng_y, 2);
    tick();
    rng_done_p = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("busy_after_last", busy, 0);
    check("valid_after_last", word_valid, 0);

    // Backpressure
    tick();
    word_ready = 1'b0;
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    tick();
    rng_y = 64'h0123_4567_89AB_CDEF; rng_done_p = 1'b1;
    push_num(rng_y, 2);
    tick();
    rng_done_p = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {word_valid, word_last, word_data}, {2'b10, 32'h89AB_CDEF});
      tick();
    end
    word_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("bp_idle", busy, 0);

    // start_p in WAIT ignored, spurious done in IDLE ignored
    tick();
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    tick();
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    @(negedge clk);
    check("start_in_wait_no_enable", {rng_enable_p, busy, word_valid}, 3'b010);
    tick();
    rng_y = 64'h1111_2222_3333_4444; rng_done_p = 1'b1;
    push_num(rng_y, 2);
    tick();
    rng_done_p = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("idle_after_ignored_start", {rng_enable_p, busy}, 2'b00);
    rng_y = 64'hDEAD_BEEF_DEAD_BEEF; rng_done_p = 1'b1;
    tick();
    rng_done_p = 1'b0;
    @(negedge clk);
    check("spurious_done", {rng_enable_p, busy, word_valid}, 3'b000);
    tick();

    // Timeout / indefinite wait
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    tick();
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      check("wait_counting", {busy, timeout_p}, 2'b10);
      tick();
    end
    @(negedge clk);
`ifdef RNG_FETCH_TIMEOUT_EN
    check("timeout_pulse", {busy, timeout_p, word_valid}, 3'b010);
    tick();
    @(negedge clk);
    check("timeout_single", {busy, timeout_p}, 2'b00);
`else
    check("no_timeout", {busy, timeout_p, word_valid}, 3'b100);
    rng_y = 64'hCAFE_0001_CAFE_0000; rng_done_p = 1'b1;
    push_num(rng_y, 2);
    tick();
    rng_done_p = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("late_done_drained", busy, 0);
`endif
    tick();

    // Done on the terminal-count cycle wins over timeout
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    rng_y = 64'h0BAD_F00D_600D_D00D; rng_done_p = 1'b1;
    push_num(rng_y, 2);
    tick();
    rng_done_p = 1'b0;
    @(negedge clk);
    check("done_wins", {word_valid, timeout_p}, 2'b10);
    tick();
    tick();

    // Reset mid-STREAM after first word
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    tick();
    rng_y = 64'hAAAA_BBBB_CCCC_DDDD; rng_done_p = 1'b1;
    push_num(rng_y, 1);
    tick();
    rng_done_p = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {rng_enable_p, rng_bypass, word_valid, word_last, busy, timeout_p, word_data},
          '0);
    tick();
    rst = 1'b0;
    rng_y = 64'hEEEE_EEEE_EEEE_EEEE; rng_done_p = 1'b1;
    tick();
    rng_done_p = 1'b0;
    @(negedge clk);
    check("abandoned_done_ignored", {busy, word_valid}, 2'b00);
    fetch(64'h5555_6666_7777_8888, 1'b0);
    @(negedge clk);
    check("fresh_fetch_idle", busy, 0);

    // Bypass capture
    word_ready = 1'b1;
    bypass = 1'b1; start_p = 1'b1;
    tick();
    start_p = 1'b0; bypass = 1'b0;
    @(negedge clk);
    check("bypass_captured", rng_bypass, 1);
    tick();
    rng_y = 64'h1234_5678_9ABC_DEF0; rng_done_p = 1'b1;
    push_num(rng_y, 2);
    tick();
    rng_done_p = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("bypass_held_idle", {rng_bypass, busy}, 2'b10);
    fetch(64'h0F0F_0F0F_F0F0_F0F0, 1'b0);
    @(negedge clk);
    check("bypass_recaptured", rng_bypass, 0);

    tick(); tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
